// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_e          : controller FSM states (IDLE, RUN, MEM_WAIT, HALT)
//   REG_X0           : architectural zero register (never a hazard source)
//   MEM_TIMEOUT_DEF  : default watchdog limit in MEM_WAIT cycles
//   TO_W_DEF         : default width of the wait-cycle counter
//   PERF_W_DEF       : default width of the performance counters
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam logic [4:0] REG_X0          = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 255;
    localparam int         TO_W_DEF        = 8;
    localparam int         PERF_W_DEF      = 32;

endpackage

// File: rtl/pipe_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect
// Combinational load-use detector. Flags when the instruction in EX is a
// load whose destination (other than x0) is a source of the instruction in ID.
// Ports:
//   idex_memread_i  in  1  EX-stage instruction is a load
//   idex_rd_i       in  5  rd of EX-stage instruction
//   ifid_rs1_i      in  5  rs1 of ID-stage instruction
//   ifid_rs2_i      in  5  rs2 of ID-stage instruction
//   lu_o            out 1  load-use hazard present
// ---------------------------------------------------------------------------
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] ifid_rs1_i,
    input  logic [4:0] ifid_rs2_i,
    output logic       lu_o
);

    assign lu_o = idex_memread_i
                & (idex_rd_i != REG_X0)
                & ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller for a 5-stage pipeline. Drives the enable and
// flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers
// from load-use hazards, ID-stage taken branches and a variable-latency
// data-memory req/ack handshake, with a memory-timeout watchdog.
//
// Handshake: mem_req_o is held high while an access is outstanding; the access
// completes on the cycle mem_ack_i is sampled high with mem_req_o high. An ack
// without a request is ignored.
//
// Ports:
//   clk_i, rst_i (sync, active-high), start_i (run enable)
//   IFID_RS1addr_i/IFID_RS2addr_i, IDEX_MemRead_i, IDEX_RDaddr_i : hazard inputs
//   Branch_taken_i   : ID-stage branch resolved taken
//   EXMEM_MemRead_i/EXMEM_MemWrite_i, mem_ack_i : memory stage access
//   mem_req_o, PCWrite_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
//   EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o : pipeline controls
//   mem_err_o (sticky timeout), halted_o (FSM in HALT)
//
// Optional feature (macro PIPE_CTRL_PERF_EN): adds saturating counters
//   stall_cnt_o, flush_cnt_o, memwait_cnt_o (PERF_W bits each).
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int PERF_W      = PERF_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [4:0]        IFID_RS1addr_i,
    input  logic [4:0]        IFID_RS2addr_i,
    input  logic              IDEX_MemRead_i,
    input  logic [4:0]        IDEX_RDaddr_i,
    input  logic              Branch_taken_i,
    input  logic              EXMEM_MemRead_i,
    input  logic              EXMEM_MemWrite_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              PCWrite_o,
    output logic              IFID_en_o,
    output logic              IFID_flush_o,
    output logic              IDEX_en_o,
    output logic              IDEX_bubble_o,
    output logic              EXMEM_en_o,
    output logic              MEMWB_en_o,
    output logic              MEMWB_bubble_o,
    output logic              mem_err_o,
    output logic              halted_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
    output logic [PERF_W-1:0] memwait_cnt_o
`endif
);

    // Illegal configurations elaborate nothing extra; kept as a visible marker.
    if (MEM_TIMEOUT < 1 || PERF_W < 1) begin : g_bad_cfg
    end

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic lu;
    logic acc;
    logic active;
    logic req;
    logic freeze;

    pipe_hazard_detect u_hazard (
        .idex_memread_i (IDEX_MemRead_i),
        .idex_rd_i      (IDEX_RDaddr_i),
        .ifid_rs1_i     (IFID_RS1addr_i),
        .ifid_rs2_i     (IFID_RS2addr_i),
        .lu_o           (lu)
    );

    assign acc    = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    // Reset forces all pipeline controls low even before the state clears.
    assign active = ((state_q == RUN) | (state_q == MEM_WAIT)) & ~rst_i;
    assign req    = active & ((state_q == MEM_WAIT) | acc);
    assign freeze = req & ~mem_ack_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (acc & ~mem_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end else if (!start_i) begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    wait_cnt_d = '0;
                    state_d    = start_i ? RUN : IDLE;
                end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                    state_d    = HALT;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: priority freeze > load-use > taken branch
    always_comb begin
        PCWrite_o      = 1'b0;
        IFID_en_o      = 1'b0;
        IFID_flush_o   = 1'b0;
        IDEX_en_o      = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_en_o     = 1'b0;
        MEMWB_en_o     = 1'b0;
        MEMWB_bubble_o = 1'b0;
        if (active) begin
            if (freeze) begin
                // Upstream holds; MEM/WB takes a bubble so WB does not repeat.
                MEMWB_en_o     = 1'b1;
                MEMWB_bubble_o = 1'b1;
            end else if (lu) begin
                // ID/EX must be enabled to capture the bubble.
                IDEX_en_o     = 1'b1;
                IDEX_bubble_o = 1'b1;
                EXMEM_en_o    = 1'b1;
                MEMWB_en_o    = 1'b1;
            end else begin
                PCWrite_o    = 1'b1;
                IFID_en_o    = 1'b1;
                IDEX_en_o    = 1'b1;
                EXMEM_en_o   = 1'b1;
                MEMWB_en_o   = 1'b1;
                IFID_flush_o = Branch_taken_i;
            end
        end
    end

    assign mem_req_o = req;
    assign mem_err_o = mem_err_q;
    assign halted_o  = (state_q == HALT);

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (active & lu & ~freeze & ~&stall_cnt_q)
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (IFID_flush_o & ~&flush_cnt_q)
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            if (freeze & ~&memwait_cnt_q)
                memwait_cnt_q <= memwait_cnt_q + PERF_W'(1);
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed vector table followed by randomized stimulus checked against a
// behavioural model of the controller. Output vector bit order:
//   {mem_req, PCWrite, IFID_en, IFID_flush, IDEX_en, IDEX_bubble,
//    EXMEM_en, MEMWB_en, MEMWB_bubble, mem_err, halted}
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TO     = 4;
    localparam int PERF_W = 32;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, idex_rd = '0;
    logic       idex_mr = 1'b0, br = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0, ack = 1'b0;

    logic mem_req_o, PCWrite_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o;
    logic EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o, mem_err_o, halted_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
`endif

    pipe_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .PERF_W(PERF_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .IFID_RS1addr_i   (rs1),
        .IFID_RS2addr_i   (rs2),
        .IDEX_MemRead_i   (idex_mr),
        .IDEX_RDaddr_i    (idex_rd),
        .Branch_taken_i   (br),
        .EXMEM_MemRead_i  (ex_rd),
        .EXMEM_MemWrite_i (ex_wr),
        .mem_ack_i        (ack),
        .mem_req_o        (mem_req_o),
        .PCWrite_o        (PCWrite_o),
        .IFID_en_o        (IFID_en_o),
        .IFID_flush_o     (IFID_flush_o),
        .IDEX_en_o        (IDEX_en_o),
        .IDEX_bubble_o    (IDEX_bubble_o),
        .EXMEM_en_o       (EXMEM_en_o),
        .MEMWB_en_o       (MEMWB_en_o),
        .MEMWB_bubble_o   (MEMWB_bubble_o),
        .mem_err_o        (mem_err_o),
        .halted_o         (halted_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o),
        .memwait_cnt_o    (memwait_cnt_o)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [10:0] dut_outs();
        return {mem_req_o, PCWrite_o, IFID_en_o, IFID_flush_o, IDEX_en_o,
                IDEX_bubble_o, EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o,
                mem_err_o, halted_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks "running", "stuck" (watchdog fired) and how many cycles the
    // current access has been outstanding after the first stall cycle.
    bit m_running = 0;
    bit m_stuck   = 0;
    bit m_err     = 0;
    int m_waited  = 0;
    int m_stalls  = 0;
    int m_flushes = 0;
    int m_mwaits  = 0;

    function automatic logic [10:0] model_outs();
        bit busy, acc_now, req_now, frz, hz, pass;
        busy    = !rst_i && !m_stuck && (m_running || m_waited > 0);
        acc_now = ex_rd || ex_wr;
        req_now = busy && (m_waited > 0 || acc_now);
        frz     = req_now && !ack;
        hz      = idex_mr && idex_rd != 0 && (idex_rd == rs1 || idex_rd == rs2);
        pass    = busy && !frz && !hz;
        return {req_now,
                pass,                      // PCWrite
                pass,                      // IFID_en
                pass && br,                // IFID_flush
                busy && !frz,              // IDEX_en
                busy && !frz && hz,        // IDEX_bubble
                busy && !frz,              // EXMEM_en
                busy,                      // MEMWB_en
                frz,                       // MEMWB_bubble
                m_err, m_stuck};
    endfunction

    always @(posedge clk) begin
        logic [10:0] o;
        o = model_outs();
        if (rst_i) begin
            m_running <= 0; m_stuck <= 0; m_err <= 0; m_waited <= 0;
            m_stalls <= 0; m_flushes <= 0; m_mwaits <= 0;
        end else begin
            if (o[5]) m_stalls  <= m_stalls + 1;   // ID/EX bubble == unfrozen load-use
            if (o[7]) m_flushes <= m_flushes + 1;
            if (o[2]) m_mwaits  <= m_mwaits + 1;
            if (m_stuck) begin
                // only reset leaves
            end else if (m_waited > 0) begin
                if (ack) begin
                    m_waited  <= 0;
                    m_running <= start_i;
                end else if (m_waited == TO) begin
                    m_waited <= 0; m_running <= 0; m_stuck <= 1; m_err <= 1;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (m_running) begin
                if ((ex_rd || ex_wr) && !ack) m_waited <= 1;
                else                         m_running <= start_i;
            end else begin
                m_running <= start_i;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, start;
        logic [4:0]  rs1, rs2;
        logic        mr;
        logic [4:0]  rd;
        logic        br, exr, exw, ack;
        logic [10:0] exp;
    } vec_t;

    localparam logic [10:0] O_ZERO = 11'b0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] O_RUN  = 11'b0_1_1_0_1_0_1_1_0_0_0;
    localparam logic [10:0] O_LU   = 11'b0_0_0_0_1_1_1_1_0_0_0;
    localparam logic [10:0] O_BR   = 11'b0_1_1_1_1_0_1_1_0_0_0;
    localparam logic [10:0] O_FRZ  = 11'b1_0_0_0_0_0_0_1_1_0_0;
    localparam logic [10:0] O_ADV  = 11'b1_1_1_0_1_0_1_1_0_0_0;
    localparam logic [10:0] O_HALT = 11'b0_0_0_0_0_0_0_0_0_1_1;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic [4:0] a1, logic [4:0] a2,
                                logic m, logic [4:0] d, logic b, logic xr,
                                logic xw, logic k, logic [10:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.rs1 = a1; v.rs2 = a2; v.mr = m; v.rd = d;
        v.br = b; v.exr = xr; v.exw = xw; v.ack = k; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i = v.rst; start_i = v.start; rs1 = v.rs1; rs2 = v.rs2;
        idex_mr = v.mr; idex_rd = v.rd; br = v.br; ex_rd = v.exr;
        ex_wr = v.exw; ack = v.ack;
    endtask

    initial begin
        //              rst st rs1 rs2 mr rd br xr xw ack exp
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO)); // in reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO)); // IDLE, start
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, O_RUN));  // RUN clean
        vecs.push_back(mk(0, 1, 1, 5, 1, 5, 0, 0, 0, 0, O_LU));   // load-use rs2
        vecs.push_back(mk(0, 1, 1, 5, 0, 5, 0, 0, 0, 0, O_RUN));  // one cycle only
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, O_RUN));  // rd = x0
        vecs.push_back(mk(0, 1, 7, 3, 1, 7, 1, 0, 0, 0, O_LU));   // lu beats branch
        vecs.push_back(mk(0, 1, 7, 3, 0, 7, 1, 0, 0, 0, O_BR));   // branch alone
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));  // load, no ack
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));  // wait 1
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));  // wait 2
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, O_ADV));  // ack: advance
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));  // back in RUN
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_ADV));  // zero-stall store
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));  // store stalls
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));  // wait 1
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));  // wait 2
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));  // wait 3
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));  // wait 4 -> HALT
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, O_HALT)); // halted, inputs ignored
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, O_HALT)); // still halted
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT)); // reset edge pending
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO)); // IDLE after reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));  // enter MEM_WAIT
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_ZERO)); // reset mid-wait
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_ZERO)); // IDLE, no start
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO)); // IDLE, start
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));  // RUN, start drops
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_ZERO)); // IDLE again

        // reset
        rst_i = 1'b1;
        repeat (2) @(posedge clk);

        // directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
        end

        // randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            @(negedge clk);
            v.rst   = ($urandom_range(99) < 2);
            v.start = ($urandom_range(99) < 90);
            v.rs1   = 5'($urandom_range(3));
            v.rs2   = 5'($urandom_range(3));
            v.mr    = ($urandom_range(99) < 40);
            v.rd    = 5'($urandom_range(3));
            v.br    = ($urandom_range(99) < 25);
            v.exr   = ($urandom_range(99) < 20);
            v.exw   = ($urandom_range(99) < 15);
            v.ack   = ($urandom_range(99) < 55);
            v.exp   = '0;
            drive(v);
            #1;
            check($sformatf("rand%0d", i), 32'(dut_outs()), 32'(model_outs()));
`ifdef PIPE_CTRL_PERF_EN
            check($sformatf("stall_cnt%0d", i), stall_cnt_o, 32'(m_stalls));
            check($sformatf("flush_cnt%0d", i), flush_cnt_o, 32'(m_flushes));
            check($sformatf("memwait_cnt%0d", i), memwait_cnt_o, 32'(m_mwaits));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sources of control: load-use hazards, ID-stage taken branches, and a variable-latency data-memory req/ack handshake.
- Owns a run/idle/wait/halt FSM with a memory-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255: max consecutive MEM_WAIT cycles before halt; must be >= 1 and <= 2**TO_W-1.
- TO_W, 8: width of the wait-cycle counter.
- PERF_W, 32: width of the performance counters (optional feature).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  run enable from top level.
- IFID_RS1addr_i  in  5  rs1 of instruction in ID.
- IFID_RS2addr_i  in  5  rs2 of instruction in ID.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RDaddr_i  in  5  rd of instruction in EX.
- Branch_taken_i  in  1  ID-stage branch resolved taken.
- EXMEM_MemRead_i  in  1  MEM-stage load.
- EXMEM_MemWrite_i  in  1  MEM-stage store.
- mem_ack_i  in  1  data memory completes the access this cycle.
- mem_req_o  out  1  data memory request.
- PCWrite_o  out  1  PC update enable.
- IFID_en_o  out  1  IF/ID enable.
- IFID_flush_o  out  1  IF/ID loads NOP.
- IDEX_en_o  out  1  ID/EX enable.
- IDEX_bubble_o  out  1  ID/EX loads zero controls.
- EXMEM_en_o  out  1  EX/MEM enable.
- MEMWB_en_o  out  1  MEM/WB enable.
- MEMWB_bubble_o  out  1  MEM/WB loads zero controls.
- mem_err_o  out  1  sticky timeout error.
- halted_o  out  1  FSM in HALT.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALT. Reset (rst_i=1 at an edge, any state including mid-wait) -> IDLE, wait_cnt=0, mem_err_o=0. Reset overrides all inputs.
- Outputs are combinational from state and inputs. In IDLE and HALT every output is 0 except mem_err_o and halted_o.
- IDLE: start_i=1 -> RUN next cycle.
- RUN with start_i=0 and no pending access -> IDLE next cycle.
- Definitions:
  - acc = EXMEM_MemRead_i | EXMEM_MemWrite_i.
  - mem_req_o = acc in RUN; 1 in MEM_WAIT.
  - freeze = mem_req_o & ~mem_ack_i.
  - lu = IDEX_MemRead_i & (IDEX_RDaddr_i != 0) & (IDEX_RDaddr_i == IFID_RS1addr_i | IDEX_RDaddr_i == IFID_RS2addr_i).
- Priority in RUN/MEM_WAIT: freeze > lu > Branch_taken_i.
- freeze=1:
  - All *_en_o and PCWrite_o = 0.
  - MEMWB_bubble_o=1, MEMWB_en_o=1 (bubble written).
  - IFID_flush_o=0, IDEX_bubble_o=0.
- freeze=0 and lu=1:
  - PCWrite_o=0, IFID_en_o=0, IDEX_bubble_o=1.
  - EX/MEM and MEM/WB enabled.
  - Branch ignored this cycle, no flush.
- freeze=0, lu=0, Branch_taken_i=1: all enables 1, IFID_flush_o=1.
- Otherwise: all enables 1, no flush/bubble.
- RUN, acc & ~mem_ack_i -> MEM_WAIT, wait_cnt=1. acc & mem_ack_i is a zero-stall access; stay RUN.
- MEM_WAIT:
  - mem_ack_i=1 -> pipeline advances this cycle, wait_cnt=0, then RUN (or IDLE if start_i=0).
  - start_i is ignored while waiting.
  - ack absent and wait_cnt==MEM_TIMEOUT -> HALT, mem_err_o=1. Otherwise wait_cnt++.
- HALT exits only by reset. mem_ack_i outside a request is ignored.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined: adds outputs stall_cnt_o, flush_cnt_o, memwait_cnt_o, each PERF_W wide.
  - stall_cnt_o increments on each cycle with lu & ~freeze in RUN/MEM_WAIT.
  - flush_cnt_o increments on each IFID_flush_o cycle.
  - memwait_cnt_o increments on each freeze cycle.
  - All saturate at all-ones and clear on reset.
- When undefined: ports absent, no counter logic.

Decomposition:
- Package pipe_ctrl_pkg: state enum (IDLE/RUN/MEM_WAIT/HALT), REG_X0 = 5'd0, default MEM_TIMEOUT constant.
- Sub-module pipe_hazard_detect: combinational load-use compare producing lu. The FSM, priority mux and counters stay in pipe_ctrl.

Test Plan:
- Reset, start_i=1: IDLE -> RUN in 1 cycle. Outputs all 0 during reset; enables all 1 in RUN with no hazards.
- IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5 -> PCWrite_o=0, IFID_en_o=0, IDEX_bubble_o=1 for exactly that cycle. Repeat with rd=0 -> no stall.
- Load-use and Branch_taken_i=1 same cycle -> stall only, IFID_flush_o=0. Next cycle branch alone -> IFID_flush_o=1.
- EXMEM_MemRead_i=1, ack after 3 cycles -> mem_req_o high 4 cycles, 3 freeze cycles with MEMWB_bubble_o=1, advance on ack cycle, back to RUN.
- MEM_TIMEOUT=4, ack never -> HALT after 4 wait cycles, mem_err_o=1, halted_o=1. Stays halted until rst_i; rst_i mid-MEM_WAIT -> IDLE next edge.
- With PIPE_CTRL_PERF_EN: 2 load-use stalls, 1 flush, 3-cycle mem wait -> stall_cnt_o=2, flush_cnt_o=1, memwait_cnt_o=3.
